// File: rtl/otter_intr_ctrl.sv
// Interrupt controller for the OTTER core: edge-triggered pending bits, mask, fixed priority, IDLE/ASSERT/SERVICE handshake.
// Build option: define INTR_SYNC_EN to pass IRQ through a 2-flop synchronizer before edge detection.
module otter_intr_ctrl (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [3:0] IRQ,
   input  logic       MIE,
   input  logic       MASK_WE,
   input  logic [3:0] MASK_WD,
   input  logic       INT_TAKEN,
   input  logic       MRET,
   output logic       INT,
   output logic [1:0] INT_CAUSE,
   output logic [3:0] PENDING,
   output logic [3:0] MASK,
   output logic [1:0] STATE
);

   // Handshake: INT is held while in ASSERT; the control FSM acknowledges with a
   // one-cycle INT_TAKEN, and the handler ends with a one-cycle MRET.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t     state;
   logic [3:0] irq_det;
   logic [3:0] irq_prev;
   logic [3:0] rise;
   logic [3:0] ep;
   logic [3:0] clr;
   logic [1:0] sel;
   logic       req;

`ifdef INTR_SYNC_EN
   logic [3:0] sync_q1;
   logic [3:0] sync_q2;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_q1 <= 4'b0000;
         sync_q2 <= 4'b0000;
      end else begin
         sync_q1 <= IRQ;
         sync_q2 <= sync_q1;
      end
   end

   assign irq_det = sync_q2;
`else
   assign irq_det = IRQ;
`endif

   // History resets to 0 so a source already high at reset release counts as an edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) irq_prev <= 4'b0000;
      else        irq_prev <= irq_det;
   end

   assign rise = irq_det & ~irq_prev;
   assign ep   = PENDING & MASK;
   assign req  = MIE & (|ep);

   always_comb begin
      sel = 2'd0;
      if      (ep[0]) sel = 2'd0;
      else if (ep[1]) sel = 2'd1;
      else if (ep[2]) sel = 2'd2;
      else if (ep[3]) sel = 2'd3;
   end

   always_comb begin
      clr = 4'b0000;
      if (state == ST_ASSERT && INT_TAKEN) clr[INT_CAUSE] = 1'b1;
   end

   // Set wins over clear so an edge arriving during acknowledge is never lost.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         PENDING <= 4'b0000;
         MASK    <= 4'b0000;
      end else begin
         PENDING <= (PENDING & ~clr) | rise;
         if (MASK_WE) MASK <= MASK_WD;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= ST_IDLE;
         INT_CAUSE <= 2'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  state     <= ST_ASSERT;
                  INT_CAUSE <= sel;
               end
            end
            ST_ASSERT: begin
               if (INT_TAKEN)  state     <= ST_SERVICE;
               else if (!req)  state     <= ST_IDLE;
               else            INT_CAUSE <= sel;
            end
            ST_SERVICE: begin
               if (MRET) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign INT   = (state == ST_ASSERT);
   assign STATE = state;

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Bench for otter_intr_ctrl: directed vector table, hand sequences for multi-cycle corners, randomized run vs a behavioural model.
module tb_otter_intr_ctrl;

`ifdef INTR_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       CLK;
   logic       RST_N;
   logic [3:0] IRQ;
   logic       MIE;
   logic       MASK_WE;
   logic [3:0] MASK_WD;
   logic       INT_TAKEN;
   logic       MRET;
   logic       INT;
   logic [1:0] INT_CAUSE;
   logic [3:0] PENDING;
   logic [3:0] MASK;
   logic [1:0] st_dbg;

   otter_intr_ctrl dut (
      .CLK(CLK), .RST_N(RST_N), .IRQ(IRQ), .MIE(MIE), .MASK_WE(MASK_WE),
      .MASK_WD(MASK_WD), .INT_TAKEN(INT_TAKEN), .MRET(MRET), .INT(INT),
      .INT_CAUSE(INT_CAUSE), .PENDING(PENDING), .MASK(MASK), .STATE(st_dbg)
   );

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   int total = 0;
   int bad   = 0;
   logic [10:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   bit         m_asserting;
   bit         m_servicing;
   int         m_cause;
   logic [3:0] m_pend;
   logic [3:0] m_mask;
   logic [3:0] m_prev;
   logic [3:0] m_hist[$];

   function automatic int lowest(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_asserting = 0;
      m_servicing = 0;
      m_cause     = 0;
      m_pend      = 4'b0;
      m_mask      = 4'b0;
      m_prev      = 4'b0;
      m_hist.delete();
      repeat (LAT) m_hist.push_back(4'b0);
   endtask

   task automatic model_edge();
      logic [3:0] det, rise, ep, clr;
      bit req;
      m_hist.push_back(IRQ);
      det    = m_hist.pop_front();
      rise   = det & ~m_prev;
      m_prev = det;
      ep     = m_pend & m_mask;
      req    = MIE && (ep != 4'b0);
      clr    = 4'b0;
      if (m_servicing) begin
         if (MRET) m_servicing = 0;
      end else if (m_asserting) begin
         if (INT_TAKEN) begin
            m_asserting  = 0;
            m_servicing  = 1;
            clr[m_cause] = 1'b1;
         end else if (!req) begin
            m_asserting = 0;
         end else begin
            m_cause = lowest(ep);
         end
      end else if (req) begin
         m_asserting = 1;
         m_cause     = lowest(ep);
      end
      m_pend = (m_pend & ~clr) | rise;
      if (MASK_WE) m_mask = MASK_WD;
      exp_q.push_back({m_asserting, 2'(m_cause), m_pend, m_mask});
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      model_edge();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic clear_strobes();
      MASK_WE   = 1'b0;
      INT_TAKEN = 1'b0;
      MRET      = 1'b0;
   endtask

   task automatic check_outs(input string tag, input logic e_int, input logic [1:0] e_cause,
                             input logic [3:0] e_pend, input logic [3:0] e_mask);
      check({tag, "_int"},   INT,       e_int);
      check({tag, "_cause"}, INT_CAUSE, e_cause);
      check({tag, "_pend"},  PENDING,   e_pend);
      check({tag, "_mask"},  MASK,      e_mask);
   endtask

   typedef struct {
      logic [3:0] irq;
      logic       mie;
      logic       we;
      logic [3:0] wd;
      logic       tk;
      logic       mr;
      logic       settle;
      logic       e_int;
      logic [1:0] e_cause;
      logic [3:0] e_pend;
      logic [3:0] e_mask;
   } vec_t;

   vec_t tbl[19];

   initial begin
      logic [10:0] e;

      // irq, mie, we, wd, tk, mr, settle | int, cause, pend, mask
      tbl[0]  = '{4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b1111};
      tbl[1]  = '{4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0100, 4'b1111};
      tbl[2]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b1111};
      tbl[3]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b1111};
      tbl[4]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b1111};
      tbl[5]  = '{4'b1010, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 4'b1010, 4'b1111};
      tbl[6]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1010, 4'b1111};
      tbl[7]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'b1000, 4'b1111};
      tbl[8]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'b1000, 4'b1111};
      tbl[9]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 4'b1111};
      tbl[10] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b1111};
      tbl[11] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b1111};
      tbl[12] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000};
      tbl[13] = '{4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0001, 4'b0000};
      tbl[14] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0001, 4'b0000};
      tbl[15] = '{4'b0000, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0001, 4'b0001};
      tbl[16] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0001};
      tbl[17] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 4'b0001};
      tbl[18] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0001};

      RST_N = 1'b0;
      IRQ = 4'b0; MIE = 1'b0; MASK_WD = 4'b0;
      clear_strobes();
      model_reset();
      #1;
      check_outs("reset", 1'b0, 2'd0, 4'b0000, 4'b0000);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;

      // ---------------- directed vector table ----------------
      for (int i = 0; i < 19; i++) begin
         IRQ       = tbl[i].irq;
         MIE       = tbl[i].mie;
         MASK_WE   = tbl[i].we;
         MASK_WD   = tbl[i].wd;
         INT_TAKEN = tbl[i].tk;
         MRET      = tbl[i].mr;
         step();
         clear_strobes();
         if (tbl[i].settle) repeat (LAT) step();
         check_outs($sformatf("vec%0d", i), tbl[i].e_int, tbl[i].e_cause, tbl[i].e_pend, tbl[i].e_mask);
      end

      // New IRQ[0] edge lands on the same edge that clears PENDING[0].
      IRQ = 4'b0001;
      repeat (LAT) step();
      INT_TAKEN = 1'b1;
      step();
      clear_strobes();
      check_outs("setclr", 1'b0, 2'd0, 4'b0001, 4'b0001);
      for (int i = 0; i < 3; i++) begin
         step();
         check("svc_hold_int", INT, 1'b0);
         check("svc_hold_pend", PENDING, 4'b0001);
      end
      MRET = 1'b1;
      step();
      clear_strobes();
      check("mret_idle_int", INT, 1'b0);
      step();
      check_outs("reassert", 1'b1, 2'd0, 4'b0001, 4'b0001);
      MRET = 1'b1;
      step();
      clear_strobes();
      check("mret_in_assert_int", INT, 1'b1);
      INT_TAKEN = 1'b1;
      step();
      check("level_no_reset_pend", PENDING, 4'b0000);
      check("take_int", INT, 1'b0);
      step();
      clear_strobes();
      check("take_in_svc_int", INT, 1'b0);
      MRET = 1'b1;
      step();
      clear_strobes();
      IRQ = 4'b0000;
      step();

      // Async reset while INT is asserted, then a source held high across release.
      IRQ = 4'b1000; MASK_WE = 1'b1; MASK_WD = 4'b1111;
      step();
      clear_strobes();
      repeat (LAT) step();
      step();
      check_outs("pre_rst", 1'b1, 2'd3, 4'b1000, 4'b1111);
      #2;
      RST_N = 1'b0;
      model_reset();
      #1;
      check_outs("async_rst", 1'b0, 2'd0, 4'b0000, 4'b0000);
      IRQ = 4'b0010;
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      MIE = 1'b1; MASK_WE = 1'b1; MASK_WD = 4'b1111;
      step();
      clear_strobes();
      repeat (LAT) step();
      check_outs("rel_edge", 1'b0, 2'd0, 4'b0010, 4'b1111);
      step();
      check_outs("rel_int", 1'b1, 2'd1, 4'b0010, 4'b1111);

      // ---------------- randomized run vs model ----------------
      exp_q.delete();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) IRQ = IRQ ^ 4'(1 << $urandom_range(0, 3));
         MIE       = ($urandom_range(0, 9) != 0);
         MASK_WE   = ($urandom_range(0, 15) == 0);
         MASK_WD   = 4'($urandom_range(0, 15));
         INT_TAKEN = ($urandom_range(0, 2) == 0);
         MRET      = ($urandom_range(0, 3) == 0);
         step();
         e = exp_q.pop_front();
         check("rnd_int",   INT,       e[10]);
         check("rnd_cause", INT_CAUSE, e[9:8]);
         check("rnd_pend",  PENDING,   e[7:4]);
         check("rnd_mask",  MASK,      e[3:0]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
